// File: rtl/tof_phase_sequencer_if.sv
// Control/status bundle between the ToF phase sequencer, its frame controller,
// the two-phase clock divider and the sensor readout block.
interface tof_phase_sequencer_if #(
   parameter int unsigned DIVISOR_BITS = 8,
   parameter int unsigned INTEG_BITS   = 16
);
   logic                    start;
   logic                    continuous;
   logic                    abort;
   logic [DIVISOR_BITS-1:0] divisor_cfg;
   logic [INTEG_BITS-1:0]   integ_cycles;
   logic                    readout_ack;
   logic [DIVISOR_BITS-1:0] divisor;
   logic [DIVISOR_BITS-1:0] phase;
   logic                    div_rst;
   logic                    illum_en;
   logic [1:0]              phase_idx;
   logic                    readout_req;
   logic                    frame_done;
   logic                    busy;
   logic                    cfg_err;

   modport master (
      output start, continuous, abort, divisor_cfg, integ_cycles, readout_ack,
      input  divisor, phase, div_rst, illum_en, phase_idx, readout_req,
             frame_done, busy, cfg_err
   );

   modport slave (
      input  start, continuous, abort, divisor_cfg, integ_cycles, readout_ack,
      output divisor, phase, div_rst, illum_en, phase_idx, readout_req,
             frame_done, busy, cfg_err
   );
endinterface

// File: rtl/tof_phase_sequencer.sv
// Sequences the 0/90/180/270 deg steps of one ToF frame: programs the clock divider,
// opens the integration window and hands each step to sensor readout.
module tof_phase_sequencer #(
   parameter int unsigned DIVISOR_BITS  = 8,
   parameter int unsigned INTEG_BITS    = 16,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   tof_phase_sequencer_if.slave bus
);
   localparam int unsigned PROD_BITS = DIVISOR_BITS + 2;
   localparam int unsigned CNT_BITS  = INTEG_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SETTLE, S_INTEG, S_READOUT
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DIVISOR_BITS-1:0] r_div_cfg;
   logic [INTEG_BITS-1:0]   r_integ;
   logic [CNT_BITS-1:0]     r_cnt;
   logic [1:0]              r_phase_idx;
   logic [DIVISOR_BITS-1:0] r_divisor;
   logic [DIVISOR_BITS-1:0] r_phase;
   logic                    r_div_rst;
   logic                    r_illum_en;
   logic                    r_readout_req;
   logic                    r_frame_done;
   logic                    r_busy;
   logic                    r_cfg_err;

   logic                    w_cfg_ok;
   logic                    w_cnt_zero;
   logic                    w_load_cfg;
   logic [CNT_BITS-1:0]     w_cnt_nxt;
   logic [1:0]              w_phase_idx_nxt;
   logic                    w_frame_done_nxt;
   logic                    w_cfg_err_nxt;
   logic [DIVISOR_BITS-1:0] w_div_cfg_nxt;
   logic [PROD_BITS-1:0]    w_prod;
   logic [DIVISOR_BITS-1:0] w_phase_nxt;

   assign w_cfg_ok   = bus.divisor_cfg >= DIVISOR_BITS'(2);
   assign w_cnt_zero = r_cnt == '0;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Abort overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:    if (bus.start && w_cfg_ok) w_state_nxt = S_SETUP;
            S_SETUP:   w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_cnt_zero) w_state_nxt = S_INTEG;
            S_INTEG:   if (w_cnt_zero) w_state_nxt = S_READOUT;
            S_READOUT: if (bus.readout_ack)
                          w_state_nxt = (r_phase_idx != 2'd3 || bus.continuous) ? S_SETUP : S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Counter reloads, step advance and pulse generation; phase_idx wraps 3->0 on restart.
   always_comb begin
      w_load_cfg       = 1'b0;
      w_cnt_nxt        = r_cnt;
      w_phase_idx_nxt  = r_phase_idx;
      w_frame_done_nxt = 1'b0;
      w_cfg_err_nxt    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_phase_idx_nxt = '0;
            if (bus.start) begin
               w_load_cfg    = w_cfg_ok;
               w_cfg_err_nxt = !w_cfg_ok;
            end
         end
         S_SETUP:  w_cnt_nxt = CNT_BITS'(SETTLE_CYCLES - 1);
         S_SETTLE: begin
            if (w_cnt_zero)
               w_cnt_nxt = (r_integ == '0) ? '0 : r_integ - INTEG_BITS'(1);
            else
               w_cnt_nxt = r_cnt - CNT_BITS'(1);
         end
         S_INTEG:  if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_BITS'(1);
         S_READOUT: begin
            if (bus.readout_ack) begin
               w_phase_idx_nxt  = r_phase_idx + 2'd1;
               w_frame_done_nxt = r_phase_idx == 2'd3;
            end
         end
         default: w_phase_idx_nxt = '0;
      endcase
      if (bus.abort) begin
         w_load_cfg       = 1'b0;
         w_phase_idx_nxt  = '0;
         w_frame_done_nxt = 1'b0;
         w_cfg_err_nxt    = 1'b0;
      end
      w_div_cfg_nxt = w_load_cfg ? bus.divisor_cfg : r_div_cfg;
      w_prod        = PROD_BITS'(w_div_cfg_nxt) * PROD_BITS'(w_phase_idx_nxt);
      w_phase_nxt   = DIVISOR_BITS'(w_prod >> 2);
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cfg     <= '0;
         r_integ       <= '0;
         r_cnt         <= '0;
         r_phase_idx   <= '0;
         r_divisor     <= '0;
         r_phase       <= '0;
         r_div_rst     <= 1'b1;
         r_illum_en    <= 1'b0;
         r_readout_req <= 1'b0;
         r_frame_done  <= 1'b0;
         r_busy        <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         if (w_load_cfg) begin
            r_div_cfg <= bus.divisor_cfg;
            r_integ   <= bus.integ_cycles;
         end
         r_cnt       <= w_cnt_nxt;
         r_phase_idx <= w_phase_idx_nxt;
         if (w_state_nxt == S_SETUP) begin
            r_divisor <= w_div_cfg_nxt;
            r_phase   <= w_phase_nxt;
         end
         r_div_rst     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SETUP);
         r_illum_en    <= w_state_nxt == S_INTEG;
         r_readout_req <= w_state_nxt == S_READOUT;
         r_busy        <= w_state_nxt != S_IDLE;
         r_frame_done  <= w_frame_done_nxt;
         r_cfg_err     <= w_cfg_err_nxt;
      end
   end

   assign bus.divisor     = r_divisor;
   assign bus.phase       = r_phase;
   assign bus.div_rst     = r_div_rst;
   assign bus.illum_en    = r_illum_en;
   assign bus.phase_idx   = r_phase_idx;
   assign bus.readout_req = r_readout_req;
   assign bus.frame_done  = r_frame_done;
   assign bus.busy        = r_busy;
   assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_tof_phase_sequencer.sv
// Scoreboard bench for tof_phase_sequencer: the driver queues the events a frame should
// produce, a monitor pops and compares them as the sequencer presents them.
module tb_tof_phase_sequencer;
   localparam int unsigned DB = 8;
   localparam int unsigned IB = 16;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_in = ~clk_in;

   tof_phase_sequencer_if #(.DIVISOR_BITS(DB), .INTEG_BITS(IB)) dif();

   tof_phase_sequencer #(.DIVISOR_BITS(DB), .INTEG_BITS(IB), .SETTLE_CYCLES(4)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (dif)
   );

   typedef enum int {EV_STEP, EV_FRAME, EV_CFGERR} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       idx;
      int       div;
      int       ph;
      int       illum;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  ack_fixed = -1;
   bit  stray_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Reference model: a frame is four steps at phase floor(k*D/4), each integrating max(I,1) cycles.
   function automatic void push_steps(input int d, input int ig, input int n);
      for (int k = 0; k < n; k++) begin
         ev_t e;
         e.kind  = EV_STEP;
         e.idx   = k;
         e.div   = d;
         e.ph    = (d * k) / 4;
         e.illum = (ig == 0) ? 1 : ig;
         exp_q.push_back(e);
      end
   endfunction

   function automatic void push_other(input ev_kind_t kind);
      ev_t e;
      e.kind  = kind;
      e.idx   = 0;
      e.div   = 0;
      e.ph    = 0;
      e.illum = 0;
      exp_q.push_back(e);
   endfunction

   function automatic void push_frame(input int d, input int ig);
      push_steps(d, ig, 4);
      push_other(EV_FRAME);
   endfunction

   // Monitor: integrates illum_en per step and compares every presented event with the queue head.
   initial begin
      bit prev_req = 1'b0;
      int illum_cnt = 0;
      ev_t e;
      forever begin
         @(negedge clk_in);
         if (!rst_n) begin
            prev_req  = 1'b0;
            illum_cnt = 0;
         end else begin
            if (dif.div_rst) illum_cnt = 0;
            else if (dif.illum_en) illum_cnt++;
            if (dif.readout_req && !prev_req) begin
               if (exp_q.size() == 0) timeout_fail("unexpected_step");
               else begin
                  e = exp_q.pop_front();
                  check("ev_kind_step", EV_STEP, e.kind);
                  check("step_idx", dif.phase_idx, e.idx);
                  check("step_divisor", dif.divisor, e.div);
                  check("step_phase", dif.phase, e.ph);
                  check("step_illum_len", illum_cnt, e.illum);
                  check("step_div_rst", dif.div_rst, 0);
               end
            end
            if (dif.frame_done) begin
               if (exp_q.size() == 0) timeout_fail("unexpected_frame_done");
               else begin
                  e = exp_q.pop_front();
                  check("ev_kind_frame", EV_FRAME, e.kind);
               end
            end
            if (dif.cfg_err) begin
               if (exp_q.size() == 0) timeout_fail("unexpected_cfg_err");
               else begin
                  e = exp_q.pop_front();
                  check("ev_kind_cfgerr", EV_CFGERR, e.kind);
               end
            end
            prev_req = dif.readout_req;
         end
      end
   end

   // Readout responder: acks each request after a fixed or random delay, plus optional stray acks.
   initial begin
      int d;
      dif.readout_ack = 1'b0;
      forever begin
         @(negedge clk_in);
         if (rst_n && dif.readout_req) begin
            d = (ack_fixed >= 0) ? ack_fixed : $urandom_range(0, 3);
            repeat (d) @(negedge clk_in);
            dif.readout_ack = 1'b1;
            @(negedge clk_in);
            dif.readout_ack = 1'b0;
         end else if (stray_ack && $urandom_range(0, 7) == 0) begin
            dif.readout_ack = 1'b1;
            @(negedge clk_in);
            dif.readout_ack = 1'b0;
         end
      end
   end

   task automatic start_frame(input int d, input int ig, input bit cont);
      @(negedge clk_in);
      dif.divisor_cfg  = DB'(d);
      dif.integ_cycles = IB'(ig);
      dif.continuous   = cont;
      dif.start        = 1'b1;
      @(negedge clk_in);
      dif.start        = 1'b0;
      dif.divisor_cfg  = DB'($urandom_range(0, 255));
      dif.integ_cycles = IB'($urandom_range(0, 40));
   endtask

   // Waits for idle, optionally pulsing start with random config while busy.
   task automatic wait_idle(input int budget, input bit stray);
      int cyc = 0;
      bit done = 1'b0;
      while (!done) begin
         @(negedge clk_in);
         dif.start = 1'b0;
         cyc++;
         if (!dif.busy) done = 1'b1;
         else if (cyc >= budget) begin
            timeout_fail("wait_idle");
            done = 1'b1;
         end else if (stray && $urandom_range(0, 15) == 0) begin
            dif.divisor_cfg = DB'($urandom_range(0, 255));
            dif.start       = 1'b1;
         end
      end
      @(negedge clk_in);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_divisor"}, dif.divisor, 0);
      check({tag, "_phase"}, dif.phase, 0);
      check({tag, "_div_rst"}, dif.div_rst, 1);
      check({tag, "_phase_idx"}, dif.phase_idx, 0);
      check({tag, "_illum_en"}, dif.illum_en, 0);
      check({tag, "_readout_req"}, dif.readout_req, 0);
      check({tag, "_frame_done"}, dif.frame_done, 0);
      check({tag, "_busy"}, dif.busy, 0);
      check({tag, "_cfg_err"}, dif.cfg_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d, ig, cyc, seen;
      bit found, busy_seen;
      dif.start        = 1'b0;
      dif.continuous   = 1'b0;
      dif.abort        = 1'b0;
      dif.divisor_cfg  = '0;
      dif.integ_cycles = '0;
      #12;
      check_reset_outputs("por");
      @(negedge clk_in);
      rst_n = 1'b1;

      // Directed single-shot frames with a fixed 2-cycle ack.
      ack_fixed = 2;
      push_frame(8, 10);   start_frame(8, 10, 1'b0);   wait_idle(2000, 1'b0);
      check("idle_after_frame", dif.busy, 0);
      ack_fixed = -1;
      push_frame(10, 5);   start_frame(10, 5, 1'b0);   wait_idle(2000, 1'b0);
      push_frame(255, 3);  start_frame(255, 3, 1'b0);  wait_idle(2000, 1'b0);
      push_frame(2, 0);    start_frame(2, 0, 1'b0);    wait_idle(2000, 1'b0);

      // Bad divisor: one cfg_err pulse, never busy.
      for (int b = 0; b < 2; b++) begin
         push_other(EV_CFGERR);
         start_frame(b, 7, 1'b0);
         busy_seen = 1'b0;
         repeat (5) begin
            @(negedge clk_in);
            busy_seen |= dif.busy;
         end
         check("cfg_err_not_busy", busy_seen, 0);
         check("cfg_err_queue", exp_q.size(), 0);
      end

      // Continuous: three frames, continuous dropped during the third.
      stray_ack = 1'b1;
      for (int f = 0; f < 3; f++) push_frame(37, 6);
      start_frame(37, 6, 1'b1);
      seen = 0;
      cyc  = 0;
      while (seen < 2 && cyc < 4000) begin
         @(negedge clk_in);
         cyc++;
         if (dif.frame_done) seen++;
      end
      if (seen < 2) timeout_fail("continuous_frames");
      repeat (10) @(negedge clk_in);
      dif.continuous = 1'b0;
      wait_idle(4000, 1'b1);

      // Abort during integration of step 2.
      push_steps(20, 12, 2);
      start_frame(20, 12, 1'b0);
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < 3000) begin
         @(negedge clk_in);
         cyc++;
         if (dif.phase_idx == 2'd2 && dif.illum_en) found = 1'b1;
      end
      if (!found) timeout_fail("abort_wait");
      dif.abort = 1'b1;
      @(negedge clk_in);
      dif.abort = 1'b0;
      check("abort_busy", dif.busy, 0);
      check("abort_illum_en", dif.illum_en, 0);
      check("abort_readout_req", dif.readout_req, 0);
      check("abort_div_rst", dif.div_rst, 1);
      check("abort_phase_idx", dif.phase_idx, 0);
      repeat (4) @(negedge clk_in);
      check("abort_queue", exp_q.size(), 0);
      push_frame(20, 4);  start_frame(20, 4, 1'b0);  wait_idle(2000, 1'b1);

      // Asynchronous reset in the middle of step 1 readout.
      ack_fixed = 5;
      push_frame(100, 3);
      start_frame(100, 3, 1'b0);
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < 3000) begin
         @(negedge clk_in);
         cyc++;
         if (dif.readout_req && dif.phase_idx == 2'd1) found = 1'b1;
      end
      if (!found) timeout_fail("reset_wait");
      @(posedge clk_in);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      exp_q.delete();
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      ack_fixed = -1;

      // Randomised frames with stray starts/acks and occasional bad divisors.
      for (int n = 0; n < 8; n++) begin
         d  = $urandom_range(2, 255);
         ig = $urandom_range(0, 25);
         if ($urandom_range(0, 4) == 0) begin
            d = $urandom_range(0, 1);
            push_other(EV_CFGERR);
         end else begin
            push_frame(d, ig);
         end
         start_frame(d, ig, 1'b0);
         wait_idle(3000, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
